// File: rtl/add_seq_ctrl.sv
// Round-robin sequencer sharing one 25-input add reduction datapath between NREQ requesters.
// Optional ADD_SEQ_STATS_EN adds a 16-bit completed-response counter on stat_cnt.
module add_seq_ctrl #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 25,
  parameter int unsigned LAT  = 1,
  parameter int unsigned IDW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_data,
  output logic [W-1:0]      dp_op,
  output logic              dp_on,
  output logic              dp_rst,
  input  logic              dp_out,
  output logic              busy
`ifdef ADD_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_cnt
`endif
);

  localparam int unsigned CNTW = 3;
  localparam int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    hold_q, hold_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            data_q, data_d;
  logic            valid_q, valid_d;
  logic            on_q, on_d;
  logic            busy_q, busy_d;
  logic            dprst_q;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic            hi_vld, lo_vld;
  logic [IDW-1:0]  hi_idx, lo_idx;
  logic [W-1:0]    sel_op;

  // Round robin: lowest valid index above last_grant wins, else lowest valid index overall.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_valid[SELW'(i)]) begin
        if (IDW'(i) > last_q) begin
          if (!hi_vld) begin
            hi_vld = 1'b1;
            hi_idx = IDW'(i);
          end
        end else if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_idx = IDW'(i);
        end
      end
    end
    gnt_vld = hi_vld | lo_vld;
    gnt_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    req_ready = '0;
    sel_op    = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready[SELW'(i)] = (state_q == S_IDLE) && gnt_vld && (gnt_idx == IDW'(i));
      if (gnt_idx == IDW'(i)) begin
        sel_op = req_op[i*W +: W];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          hold_d  = sel_op;
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNTW'(LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNTW'(1)) begin
          data_d  = dp_out;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_RESP);
    on_d    = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      on_q    <= 1'b0;
      busy_q  <= 1'b0;
      dprst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      on_q    <= on_d;
      busy_q  <= busy_d;
      dprst_q <= 1'b1;
    end
  end

  assign resp_valid = valid_q;
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign dp_op      = hold_q;
  assign dp_on      = on_q;
  assign dp_rst     = dprst_q;
  assign busy       = busy_q;

`ifdef ADD_SEQ_STATS_EN
  logic [15:0] stat_q;

  // Completed response handshakes, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
    end else if (state_q == S_RESP && resp_ready) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule
